// File: rtl/vbc_prim_fetch.sv
// vbc_prim_fetch -- vertex-buffer controller.
// PCIe DMA writes always reach the vertex RAM. PCIe DMA reads reach it while
// the block is idle or loading. After an end-of-frame write, the block streams
// primitives of WPP consecutive RAM words to the processing unit, one at a time,
// over a valid/ready handshake. It pulses o_frame_done when the unit accepts the
// primitive whose last word has bit 0 set.
//
// Optional feature macro: VBC_PRIM_CNT_EN
//   When defined, the block adds output o_prim_count, which counts the
//   primitives accepted in the current frame.
//
// Parameter limits: WPP must be 1, 2, 4 or 8. RD_LAT must be 1..4.
module vbc_prim_fetch #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 13,
  parameter int WPP    = 2,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pcie_dmawr_write,
  input  logic [ADDR_W-1:0]     i_pcie_dmawr_addr,
  input  logic [DATA_W-1:0]     i_pcie_dmawr_data,
  input  logic                  i_pcie_dmard_read,
  input  logic [ADDR_W-1:0]     i_pcie_dmard_addr,
  output logic [DATA_W-1:0]     o_pcie_dmard_data,
  output logic                  o_ram1_wren,
  output logic [ADDR_W-1:0]     o_ram1_wraddress,
  output logic [DATA_W-1:0]     o_ram1_data,
  output logic                  o_ram1_rden,
  output logic [ADDR_W-1:0]     o_ram1_rdaddress,
  input  logic [DATA_W-1:0]     i_ram1_q,
  input  logic                  i_proc_ready,
  output logic                  o_prim_valid,
  output logic [WPP*DATA_W-1:0] o_prim_data,
  output logic                  o_frame_done,
  output logic                  o_busy
`ifdef VBC_PRIM_CNT_EN
  ,
  output logic [ADDR_W-1:0]     o_prim_count
`endif
);

  // FETCH lasts WPP issue cycles plus RD_LAT drain cycles. The cycle counter
  // runs from 0 to WPP+RD_LAT-1.
  localparam int CNT_W = $clog2(WPP + RD_LAT + 1);

  localparam logic [CNT_W-1:0]  ISSUE_N  = CNT_W'(WPP);
  localparam logic [CNT_W-1:0]  LAST_CYC = CNT_W'(WPP + RD_LAT - 1);

  // The low log2(WPP) address bits select the word inside a primitive.
  // When WPP is 1, the mask is zero and the address test always passes.
  localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'(WPP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FETCH = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [ADDR_W-1:0]   fetch_addr_r;
  logic [DATA_W-1:0]   slot_r [WPP];

  logic                eof_s;
  logic                start_s;
  logic                issue_s;
  logic                accept_s;
  logic                last_s;
  logic                fetcher_owns_s;

  // Decode the handshake and frame-control events.
  always_comb begin
    eof_s          = i_pcie_dmawr_write & i_pcie_dmawr_data[0] &
                     ((i_pcie_dmawr_addr & WORD_MASK) == WORD_MASK);
    start_s        = (state_r == ST_IDLE) & i_pcie_dmawr_write;
    issue_s        = (state_r == ST_FETCH) & (cnt_r < ISSUE_N);
    accept_s       = (state_r == ST_HOLD) & i_proc_ready;
    last_s         = slot_r[WPP-1][0];
    fetcher_owns_s = (state_r == ST_FETCH) | (state_r == ST_HOLD);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic. While fetching or holding, writes and reads from the
  // host are ignored.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (eof_s) begin
          state_s = ST_FETCH;
        end else if (i_pcie_dmawr_write) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (eof_s) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_FETCH: begin
        if (cnt_r == LAST_CYC) begin
          state_s = ST_HOLD;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (accept_s) begin
          if (last_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_FETCH;
          end
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode: the handshake outputs, and the routing of the RAM ports.
  always_comb begin
    o_ram1_wren       = i_pcie_dmawr_write;
    o_ram1_wraddress  = i_pcie_dmawr_addr;
    o_ram1_data       = i_pcie_dmawr_data;
    o_pcie_dmard_data = i_ram1_q;
    o_prim_valid      = (state_r == ST_HOLD);
    o_busy            = fetcher_owns_s;
    o_frame_done      = accept_s & last_s;
    if (fetcher_owns_s) begin
      o_ram1_rden      = issue_s;
      o_ram1_rdaddress = fetch_addr_r;
    end else begin
      o_ram1_rden      = i_pcie_dmard_read;
      o_ram1_rdaddress = i_pcie_dmard_addr;
    end
  end

  // Cycle counter inside FETCH. Word k is issued at count k and captured at
  // count k+RD_LAT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (state_r == ST_FETCH) begin
      if (cnt_r == LAST_CYC) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= '0;
    end
  end

  // Fetch address. It restarts at 0 when a frame begins and advances by one on
  // every issued read, wrapping at the top of the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr_r <= '0;
    end else if (start_s) begin
      fetch_addr_r <= '0;
    end else if (issue_s) begin
      fetch_addr_r <= fetch_addr_r + ADDR_W'(1);
    end else begin
      fetch_addr_r <= fetch_addr_r;
    end
  end

  // Capture each returned word into its slot. The slots stay unchanged
  // throughout HOLD, so o_prim_data is stable while it waits for acceptance.
  always_ff @(posedge clk) begin
    for (int k = 0; k < WPP; k++) begin
      if (rst) begin
        slot_r[k] <= '0;
      end else if ((state_r == ST_FETCH) && (cnt_r == CNT_W'(k + RD_LAT))) begin
        slot_r[k] <= i_ram1_q;
      end else begin
        slot_r[k] <= slot_r[k];
      end
    end
  end

  // Word 0 sits in the most significant slice of the primitive bus.
  for (genvar g = 0; g < WPP; g++) begin : g_prim_pack
    assign o_prim_data[(WPP-g)*DATA_W-1 -: DATA_W] = slot_r[g];
  end

`ifdef VBC_PRIM_CNT_EN
  logic [ADDR_W-1:0] prim_cnt_r;

  // Count the primitives accepted in this frame. The count holds after
  // frame-done and clears when the next frame starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      prim_cnt_r <= '0;
    end else if (start_s) begin
      prim_cnt_r <= '0;
    end else if (accept_s) begin
      prim_cnt_r <= prim_cnt_r + ADDR_W'(1);
    end else begin
      prim_cnt_r <= prim_cnt_r;
    end
  end

  assign o_prim_count = prim_cnt_r;
`endif

endmodule

// File: tb/tb_vbc_prim_fetch.sv
// Self-checking bench for vbc_prim_fetch with WPP=2 and RD_LAT=1.
// A cycle-level model in the bench follows the frame timeline and predicts
// every output. Directed scenarios exercise load, streaming, backpressure,
// host reads and reset during a fetch. Literal expectations pin the model.
module tb_vbc_prim_fetch;
  localparam int DW = 128;
  localparam int AW = 13;
  localparam int WPP = 2;
  localparam int RL = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              pcie_wr = 1'b0;
  logic [AW-1:0]     pcie_wr_addr = '0;
  logic [DW-1:0]     pcie_wr_data = '0;
  logic              pcie_rd = 1'b0;
  logic [AW-1:0]     pcie_rd_addr = '0;
  logic              ready = 1'b0;
  logic [DW-1:0]     dmard_data;
  logic              ram_wren, ram_rden;
  logic [AW-1:0]     ram_wraddr, ram_rdaddr;
  logic [DW-1:0]     ram_wdata;
  logic [DW-1:0]     ram_q = '0;
  logic              prim_valid, frame_done, busy;
  logic [WPP*DW-1:0] prim_data;
`ifdef VBC_PRIM_CNT_EN
  logic [AW-1:0]     prim_count;
`endif

  vbc_prim_fetch #(.DATA_W(DW), .ADDR_W(AW), .WPP(WPP), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .i_pcie_dmawr_write(pcie_wr), .i_pcie_dmawr_addr(pcie_wr_addr), .i_pcie_dmawr_data(pcie_wr_data),
    .i_pcie_dmard_read(pcie_rd), .i_pcie_dmard_addr(pcie_rd_addr), .o_pcie_dmard_data(dmard_data),
    .o_ram1_wren(ram_wren), .o_ram1_wraddress(ram_wraddr), .o_ram1_data(ram_wdata),
    .o_ram1_rden(ram_rden), .o_ram1_rdaddress(ram_rdaddr), .i_ram1_q(ram_q),
    .i_proc_ready(ready), .o_prim_valid(prim_valid), .o_prim_data(prim_data),
    .o_frame_done(frame_done), .o_busy(busy)
`ifdef VBC_PRIM_CNT_EN
    , .o_prim_count(prim_count)
`endif
  );

  // Vertex RAM with a one-cycle read latency.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_wren) ram[ram_wraddr] <= ram_wdata;
    if (ram_rden) ram_q <= ram[ram_rdaddr];
  end

  // The bench's own record of what the host wrote.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  int errs = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkword(int i, bit eof);
    return {96'h0, 16'hBEEF, 15'(i), eof};
  endfunction

  // Model of the frame timeline. A frame starts on an end-of-frame write
  // (odd address, bit 0 set) while the block is not streaming. Each primitive
  // becomes valid WPP+RL cycles after its fetch begins.
  bit            m_active = 1'b0;
  int            m_wait = 0;
  logic [AW-1:0] m_base = '0;
  logic [AW-1:0] m_count = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_wait = 0; m_base = '0; m_count = '0;
    end else if (!m_active) begin
      if (pcie_wr) begin
        m_base = '0; m_count = '0;
        if (pcie_wr_data[0] && pcie_wr_addr[0]) begin
          m_active = 1'b1; m_wait = WPP + RL;
        end
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (ready) begin
      m_count++;
      if (ref_mem[m_base + AW'(1)][0]) begin
        m_active = 1'b0;
      end else begin
        m_base = m_base + AW'(WPP);
        m_wait = WPP + RL;
      end
    end
  end

  // Compare every DUT output with the model in the middle of each cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      logic          e_valid, e_rden;
      logic [AW-1:0] e_raddr;
      logic [255:0]  e_prim;
      int            j;
      e_prim  = {ref_mem[m_base], ref_mem[m_base + AW'(1)]};
      e_valid = m_active && (m_wait == 0);
      j       = WPP + RL - m_wait;
      e_rden  = m_active ? ((m_wait > 0) && (j < WPP)) : pcie_rd;
      e_raddr = m_active ? m_base + AW'(j) : pcie_rd_addr;
      chk("busy", busy, m_active);
      chk("prim_valid", prim_valid, e_valid);
      chk("frame_done", frame_done, e_valid && ready && e_prim[0]);
      if (e_valid) chk("prim_data", prim_data, e_prim);
      chk("rden", ram_rden, e_rden);
      if (e_rden) chk("rdaddress", ram_rdaddr, e_raddr);
      chk("wren", ram_wren, pcie_wr);
      if (pcie_wr) begin
        chk("wraddress", ram_wraddr, pcie_wr_addr);
        chk("wrdata", ram_wdata, pcie_wr_data);
      end
      chk("dmard_data", dmard_data, ram_q);
`ifdef VBC_PRIM_CNT_EN
      chk("prim_count", prim_count, m_count);
`endif
    end
  end

  // Event monitor used by the directed checks.
  int acc_n = 0, done_n = 0, cyc = 0, busy_t = 0, lat_first = -1;
  bit busy_q = 1'b0, valid_q = 1'b0, armed = 1'b0;
  logic [255:0] prim_log [$];
  always @(negedge clk) begin
    cyc++;
    if (busy && !busy_q) begin busy_t = cyc; armed = 1'b1; end
    if (prim_valid && !valid_q && armed) begin lat_first = cyc - busy_t; armed = 1'b0; end
    if (prim_valid && ready) begin acc_n++; prim_log.push_back(prim_data); end
    if (frame_done) done_n++;
    busy_q = busy; valid_q = prim_valid;
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wr(int a, logic [DW-1:0] d);
    pcie_wr = 1'b1; pcie_wr_addr = AW'(a); pcie_wr_data = d; ref_mem[AW'(a)] = d;
    tick();
    pcie_wr = 1'b0;
  endtask

  task automatic wait_done(int target, int bound, string name);
    int n = 0;
    while (done_n < target && n < bound) begin tick(); n++; end
    checks++;
    if (done_n < target) begin
      errs++;
      $display("FAIL %s: frame_done count %0d required %0d", name, done_n, target);
    end
  endtask

  task automatic wait_valid(int bound, string name);
    int n = 0;
    while (!prim_valid && n < bound) begin tick(); n++; end
    chk(name, prim_valid, 1'b1);
  endtask

  initial begin
    // Reset for three cycles.
    rst = 1'b1;
    tick();
    chk_on = 1'b1;
    tick(); tick();
    chk("rst_valid", prim_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_data", prim_data, 256'h0);
    rst = 1'b0;
    tick();

    // Load six words. Word 5 marks the end of the frame. Ready stays high.
    ready = 1'b1;
    wr(7, mkword(7, 1'b0));
    for (int i = 0; i < 6; i++) wr(i, mkword(i, i == 5));
    wait_done(1, 60, "frame1_done");
    tick();
    chk("frame1_accepts", acc_n, 3);
    chk("frame1_done_n", done_n, 1);
    chk("frame1_latency", lat_first, 3);
    chk("frame1_prim0", prim_log[0], {96'h0, 16'hBEEF, 16'h0000, 96'h0, 16'hBEEF, 16'h0002});
    chk("frame1_prim2", prim_log[2], {96'h0, 16'hBEEF, 16'h0008, 96'h0, 16'hBEEF, 16'h000B});
`ifdef VBC_PRIM_CNT_EN
    chk("count_held", prim_count, 13'd3);
`endif

    // Host read of address 7 while idle.
    pcie_rd = 1'b1; pcie_rd_addr = 13'd7;
    #1 chk("idle_rdaddr", ram_rdaddr, 13'd7);
    tick();
    pcie_rd = 1'b0;
    chk("idle_rddata", dmard_data, {96'h0, 16'hBEEF, 16'h000E});

    // Backpressure: a two-primitive frame with ready held low.
    ready = 1'b0;
    wr(0, mkword(20, 1'b0));
`ifdef VBC_PRIM_CNT_EN
    chk("count_cleared", prim_count, 13'd0);
`endif
    for (int i = 1; i < 4; i++) wr(i, mkword(20 + i, i == 3));
    wait_valid(20, "bp_valid");
    pcie_rd = 1'b1; pcie_rd_addr = 13'd100;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", prim_valid, 1'b1);
      chk("bp_hold_data", prim_data, {96'h0, 16'hBEEF, 16'd40, 96'h0, 16'hBEEF, 16'd42});
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("bp_drop_valid", prim_valid, 1'b0);
    chk("bp_one_accept", acc_n, 4);
    wait_valid(20, "bp_valid2");
    pcie_rd = 1'b0;
    ready = 1'b1;
    wait_done(2, 20, "bp_done");
    tick();

    // Reset during the first FETCH cycle.
    wr(0, mkword(30, 1'b0));
    wr(1, mkword(31, 1'b1));
    chk("fetch_entered", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_valid", prim_valid, 1'b0);
    tick(); tick(); tick(); tick();
    chk("rst_mid_no_done", done_n, 2);

    // A new frame after the reset runs normally.
    wr(0, mkword(40, 1'b0));
    wr(1, mkword(41, 1'b1));
    wait_done(3, 20, "post_rst_done");
    tick();
    chk("post_rst_prim", prim_log[prim_log.size() - 1], {96'h0, 16'hBEEF, 16'h0050, 96'h0, 16'hBEEF, 16'h0053});
    ready = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
